// File: rtl/aiva_pkg.sv
// ============================================================================
// aiva_pkg : shared opcodes, instruction field widths and sequencer states.
// Optional feature macro: AIVA_SEQ_SINGLE_STEP_EN (adds ST_STEP_WAIT).
// Revision: 1.0
// ============================================================================
`default_nettype none

package aiva_pkg;

   localparam int OPCODE_W  = 4;
   localparam int RSVD_W    = 4;
   localparam int OPERAND_W = 8;
   localparam int INSTR_W   = OPCODE_W + RSVD_W + OPERAND_W;
   localparam int ADDR_W    = 8;

   localparam logic [OPCODE_W-1:0] OP_NOP    = 4'h0;
   localparam logic [OPCODE_W-1:0] OP_JMP    = 4'h1;
   localparam logic [OPCODE_W-1:0] OP_BZ     = 4'h2;
   localparam logic [OPCODE_W-1:0] OP_ALU_LO = 4'h3;
   localparam logic [OPCODE_W-1:0] OP_ALU_HI = 4'hE;
   localparam logic [OPCODE_W-1:0] OP_HALT   = 4'hF;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_FETCH   = 3'd1,
      ST_DECODE  = 3'd2,
      ST_EXEC    = 3'd3,
      ST_ADVANCE = 3'd4,
`ifdef AIVA_SEQ_SINGLE_STEP_EN
      ST_HALT    = 3'd5,
      ST_STEP_WAIT = 3'd6
`else
      ST_HALT    = 3'd5
`endif
   } state_t;

endpackage

`default_nettype wire

// File: rtl/aiva_instr_decode.sv
// ============================================================================
// aiva_instr_decode : combinational opcode classifier for the sequencer.
// Revision: 1.0
// ============================================================================
`default_nettype none

module aiva_instr_decode
   import aiva_pkg::*;
(
   input  logic [OPCODE_W-1:0] opcode,
   output logic                is_jmp,
   output logic                is_bz,
   output logic                is_alu,
   output logic                is_halt
);

   always_comb begin
      is_jmp  = (opcode == OP_JMP);
      is_bz   = (opcode == OP_BZ);
      is_alu  = (opcode >= OP_ALU_LO) && (opcode <= OP_ALU_HI);
      is_halt = (opcode == OP_HALT);
   end

endmodule

`default_nettype wire

// File: rtl/aiva_sequencer.sv
// ============================================================================
// aiva_sequencer : fetch/decode/execute control FSM driving the Aiva PC.
// Optional feature macro: AIVA_SEQ_SINGLE_STEP_EN (step input, STEP_WAIT).
// Revision: 1.0
// ============================================================================
`default_nettype none

module aiva_sequencer
   import aiva_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
`ifdef AIVA_SEQ_SINGLE_STEP_EN
   input  logic                 step,
`endif
   output logic                 imem_req,
   input  logic                 imem_ack,
   input  logic [INSTR_W-1:0]   imem_rdata,
   output logic                 pc_en,
   output logic                 pc_branch_en,
   output logic [ADDR_W-1:0]    pc_next_addr,
   output logic                 exec_valid,
   output logic [OPCODE_W-1:0]  exec_op,
   output logic [OPERAND_W-1:0] exec_operand,
   input  logic                 exec_done,
   input  logic                 zero_flag,
   output logic                 busy,
   output logic                 halted
);

   state_t               state;
   state_t               state_next;
   logic [INSTR_W-1:0]   ir;
   logic                 branch;

   logic [OPCODE_W-1:0]  ir_op;
   logic [OPERAND_W-1:0] ir_operand;
   logic                 is_jmp;
   logic                 is_bz;
   logic                 is_alu;
   logic                 is_halt;
   logic                 unused_rsvd;

   assign ir_op       = ir[INSTR_W-1 -: OPCODE_W];
   assign ir_operand  = ir[OPERAND_W-1:0];
   // Reserved field is carried in the IR but has no meaning to the sequencer.
   assign unused_rsvd = ^ir[OPERAND_W +: RSVD_W];

   aiva_instr_decode u_decode (
      .opcode  (ir_op),
      .is_jmp  (is_jmp),
      .is_bz   (is_bz),
      .is_alu  (is_alu),
      .is_halt (is_halt)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= ST_IDLE;
         ir     <= '0;
         branch <= 1'b0;
      end else begin
         state <= state_next;
         if (state == ST_FETCH && imem_ack) begin
            ir <= imem_rdata;
         end
         if (state == ST_DECODE) begin
            branch <= is_jmp | (is_bz & zero_flag);
         end
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE: begin
            if (start) state_next = ST_FETCH;
         end
         ST_FETCH: begin
            if (imem_ack) state_next = ST_DECODE;
         end
         ST_DECODE: begin
            if (is_halt)     state_next = ST_HALT;
            else if (is_alu) state_next = ST_EXEC;
            else             state_next = ST_ADVANCE;
         end
         ST_EXEC: begin
            if (exec_done) state_next = ST_ADVANCE;
         end
         ST_ADVANCE: begin
`ifdef AIVA_SEQ_SINGLE_STEP_EN
            state_next = ST_STEP_WAIT;
`else
            state_next = ST_FETCH;
`endif
         end
`ifdef AIVA_SEQ_SINGLE_STEP_EN
         ST_STEP_WAIT: begin
            if (step) state_next = ST_FETCH;
         end
`endif
         ST_HALT: begin
            state_next = ST_HALT;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // All outputs decode registered state only, so none follow an input combinationally.
   assign imem_req     = (state == ST_FETCH);
   assign pc_en        = (state == ST_ADVANCE);
   assign pc_branch_en = (state == ST_ADVANCE) && branch;
   assign pc_next_addr = pc_branch_en ? ir_operand : '0;
   assign exec_valid   = (state == ST_EXEC);
   assign exec_op      = exec_valid ? ir_op : '0;
   assign exec_operand = exec_valid ? ir_operand : '0;
   assign busy         = (state != ST_IDLE) && (state != ST_HALT);
   assign halted       = (state == ST_HALT);

endmodule

`default_nettype wire
